// File: rtl/cache_pkg.sv
// Shared types and sizing for the DAWG-partitioned cache tag controller.
// Optional stats build: define CACHE_TAG_CTRL_STATS_EN.
package cache_pkg;

  localparam int WAY_NUM     = 4;
  localparam int INDEX_W     = 10;
  localparam int TAG_W       = 18;
  localparam int DOMAIN_NUM  = 4;
  localparam int DOM_W       = $clog2(DOMAIN_NUM);
  localparam int WAY_W       = $clog2(WAY_NUM);
  localparam int CACHE_LINES = 2**INDEX_W;

  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } cache_tag_type;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    HIT_WR,
    WB,
    FILL,
    TAG_WR,
    RESP
  } tag_ctrl_state_e;

endpackage

// File: rtl/cache_tag_ctrl_if.sv
// Core-side request/response handshake of the cache tag controller.
// master = requesting core, slave = tag controller.
interface cache_tag_ctrl_if;
  import cache_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic               req_rw;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic [DOM_W-1:0]   req_domain;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_hit;
  logic [WAY_W-1:0]   resp_way;
  logic               resp_err;

  modport master (
    output req_valid, req_rw, req_index,
    output req_tag, req_domain, resp_ready,
    input  req_ready, resp_valid, resp_hit,
    input  resp_way, resp_err
  );

  modport slave (
    input  req_valid, req_rw, req_index,
    input  req_tag, req_domain, resp_ready,
    output req_ready, resp_valid, resp_hit,
    output resp_way, resp_err
  );

endinterface

// File: rtl/cache_victim_sel.sv
// Miss victim choice: lowest free way in the domain mask,
// else the first masked way at or after the round-robin pointer.
module cache_victim_sel
  import cache_pkg::*;
(
  input  logic [WAY_NUM-1:0] valid_vec,
  input  logic [WAY_NUM-1:0] mask,
  input  logic [WAY_W-1:0]   ptr,
  output logic [WAY_W-1:0]   victim,
  output logic [WAY_W-1:0]   next_ptr,
  output logic               use_rr
);

  logic [WAY_NUM-1:0] free;
  logic               found_free;
  logic [WAY_W-1:0]   free_way;
  logic [WAY_W-1:0]   rr_way;
  logic [WAY_W-1:0]   idx;

  always_comb begin
    free       = ~valid_vec & mask;
    found_free = 1'b0;
    free_way   = '0;
    rr_way     = ptr;
    idx        = '0;
    for (int i = WAY_NUM-1; i >= 0; i--) begin
      if (free[i]) begin
        free_way   = WAY_W'(i);
        found_free = 1'b1;
      end
    end
    // Way index wraps naturally at WAY_W bits.
    for (int i = WAY_NUM-1; i >= 0; i--) begin
      idx = ptr + WAY_W'(i);
      if (mask[idx]) rr_way = idx;
    end
    use_rr   = !found_free;
    victim   = found_free ? free_way : rr_way;
    next_ptr = rr_way + WAY_W'(1);
  end

endmodule

// File: rtl/cache_tag_ctrl.sv
// Tag sequencer for the domain-partitioned set-associative cache.
// Define CACHE_TAG_CTRL_STATS_EN to add hit/miss/writeback counters.
module cache_tag_ctrl
  import cache_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  cache_tag_ctrl_if.slave             bus,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [TAG_W-1:0]            wb_tag,
  output logic                        fill_valid,
  input  logic                        fill_done,
  output logic [INDEX_W-1:0]          tag_index,
  output logic [WAY_W-1:0]            tag_way,
  output logic                        tag_req_we,
  output cache_tag_type               tag_write,
  input  cache_tag_type [WAY_NUM-1:0] tag_read,
  input  logic                        cfg_we,
  input  logic [DOM_W-1:0]            cfg_domain,
  input  logic [WAY_NUM-1:0]          cfg_mask
`ifdef CACHE_TAG_CTRL_STATS_EN
  ,
  output logic [31:0]                 stat_hits,
  output logic [31:0]                 stat_misses,
  output logic [31:0]                 stat_wbs
`endif
);

  tag_ctrl_state_e    state;
  logic               lat_rw;
  logic [INDEX_W-1:0] lat_index;
  logic [TAG_W-1:0]   lat_tag;
  logic [DOM_W-1:0]   lat_dom;
  logic [WAY_NUM-1:0] lat_mask;
  logic [WAY_W-1:0]   vic_way;
  logic [WAY_NUM-1:0] dom_mask [DOMAIN_NUM];
  logic [WAY_W-1:0]   rr_ptr   [DOMAIN_NUM];

  logic               hit;
  logic               hit_dirty;
  logic [WAY_W-1:0]   hit_way;
  logic [WAY_NUM-1:0] valid_vec;
  logic [WAY_W-1:0]   victim;
  logic [WAY_W-1:0]   next_ptr;
  logic               use_rr;

  assign tag_index = (state == IDLE) ? bus.req_index : lat_index;

  // Only ways in the latched mask may hit: no cross-domain leak.
  always_comb begin
    hit       = 1'b0;
    hit_dirty = 1'b0;
    hit_way   = '0;
    valid_vec = '0;
    for (int i = WAY_NUM-1; i >= 0; i--) begin
      valid_vec[i] = tag_read[i].valid;
      if (tag_read[i].valid && lat_mask[i] &&
          tag_read[i].tag == lat_tag) begin
        hit       = 1'b1;
        hit_dirty = tag_read[i].dirty;
        hit_way   = WAY_W'(i);
      end
    end
  end

  cache_victim_sel u_vsel (
    .valid_vec (valid_vec),
    .mask      (lat_mask),
    .ptr       (rr_ptr[lat_dom]),
    .victim    (victim),
    .next_ptr  (next_ptr),
    .use_rr    (use_rr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_hit   <= 1'b0;
      bus.resp_way   <= '0;
      bus.resp_err   <= 1'b0;
      wb_valid       <= 1'b0;
      wb_tag         <= '0;
      fill_valid     <= 1'b0;
      tag_way        <= '0;
      tag_req_we     <= 1'b0;
      tag_write      <= '0;
      lat_rw         <= 1'b0;
      lat_index      <= '0;
      lat_tag        <= '0;
      lat_dom        <= '0;
      lat_mask       <= '0;
      vic_way        <= '0;
      for (int d = 0; d < DOMAIN_NUM; d++) begin
        dom_mask[d] <= {WAY_NUM{d == 0}};
        rr_ptr[d]   <= '0;
      end
    end else begin
      if (cfg_we) dom_mask[cfg_domain] <= cfg_mask;
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_rw        <= bus.req_rw;
            lat_index     <= bus.req_index;
            lat_tag       <= bus.req_tag;
            lat_dom       <= bus.req_domain;
            lat_mask      <= dom_mask[bus.req_domain];
            bus.req_ready <= 1'b0;
            state         <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lat_mask == '0) begin
            bus.resp_err   <= 1'b1;
            bus.resp_hit   <= 1'b0;
            bus.resp_way   <= '0;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end else if (hit) begin
            bus.resp_err <= 1'b0;
            bus.resp_hit <= 1'b1;
            bus.resp_way <= hit_way;
            if (lat_rw && !hit_dirty) begin
              tag_req_we <= 1'b1;
              tag_way    <= hit_way;
              tag_write  <= '{valid: 1'b1, dirty: 1'b1, tag: lat_tag};
              state      <= HIT_WR;
            end else begin
              bus.resp_valid <= 1'b1;
              state          <= RESP;
            end
          end else begin
            bus.resp_err <= 1'b0;
            bus.resp_hit <= 1'b0;
            bus.resp_way <= victim;
            vic_way      <= victim;
            if (use_rr) rr_ptr[lat_dom] <= next_ptr;
            if (tag_read[victim].valid && tag_read[victim].dirty) begin
              wb_valid <= 1'b1;
              wb_tag   <= tag_read[victim].tag;
              state    <= WB;
            end else begin
              fill_valid <= 1'b1;
              state      <= FILL;
            end
          end
        end
        HIT_WR: begin
          tag_req_we     <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        WB: begin
          if (wb_ready) begin
            wb_valid   <= 1'b0;
            fill_valid <= 1'b1;
            state      <= FILL;
          end
        end
        FILL: begin
          if (fill_done) begin
            fill_valid <= 1'b0;
            tag_req_we <= 1'b1;
            tag_way    <= vic_way;
            tag_write  <= '{valid: 1'b1, dirty: lat_rw, tag: lat_tag};
            state      <= TAG_WR;
          end
        end
        TAG_WR: begin
          tag_req_we     <= 1'b0;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_TAG_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbs    <= '0;
    end else begin
      if (state == RESP && bus.resp_ready) begin
        if (bus.resp_hit) begin
          if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
        end else if (!bus.resp_err) begin
          if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
        end
      end
      if (state == WB && wb_ready && stat_wbs != '1)
        stat_wbs <= stat_wbs + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Directed bench for cache_tag_ctrl with a behavioural tag array
// and response/writeback scoreboards.
module tb_cache_tag_ctrl;
  import cache_pkg::*;

  typedef struct packed {
    logic             hit;
    logic [WAY_W-1:0] way;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic wb_valid, wb_ready;
  logic [TAG_W-1:0] wb_tag;
  logic fill_valid, fill_done;
  logic [INDEX_W-1:0] tag_index;
  logic [WAY_W-1:0] tag_way;
  logic tag_req_we;
  cache_tag_type tag_write;
  cache_tag_type [WAY_NUM-1:0] tag_read;
  logic cfg_we;
  logic [DOM_W-1:0] cfg_domain;
  logic [WAY_NUM-1:0] cfg_mask;
`ifdef CACHE_TAG_CTRL_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_wbs;
`endif

  cache_tag_type mem [CACHE_LINES][WAY_NUM];
  int wr_cnt = 0;
  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [TAG_W-1:0] wb_q[$];

  cache_tag_ctrl_if bus ();

  cache_tag_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_tag     (wb_tag),
    .fill_valid (fill_valid),
    .fill_done  (fill_done),
    .tag_index  (tag_index),
    .tag_way    (tag_way),
    .tag_req_we (tag_req_we),
    .tag_write  (tag_write),
    .tag_read   (tag_read),
    .cfg_we     (cfg_we),
    .cfg_domain (cfg_domain),
    .cfg_mask   (cfg_mask)
`ifdef CACHE_TAG_CTRL_STATS_EN
    ,
    .stat_hits  (stat_hits),
    .stat_misses(stat_misses),
    .stat_wbs   (stat_wbs)
`endif
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int w = 0; w < WAY_NUM; w++) tag_read[w] = mem[tag_index][w];
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int s = 0; s < CACHE_LINES; s++)
        for (int w = 0; w < WAY_NUM; w++) mem[s][w] <= '0;
    end else if (tag_req_we) begin
      mem[tag_index][tag_way] <= tag_write;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [DOM_W-1:0] d, input logic [WAY_NUM-1:0] m);
    @(negedge clk);
    cfg_we = 1'b1; cfg_domain = d; cfg_mask = m;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic txn(input logic rw, input logic [INDEX_W-1:0] idx,
                     input logic [TAG_W-1:0] tg, input logic [DOM_W-1:0] dom,
                     input logic co_cfg, input logic hit,
                     input logic [WAY_W-1:0] way, input logic err,
                     input int lat_exp, input int nwr,
                     input logic do_wb, input logic [TAG_W-1:0] wbt);
    int w0, cyc, lat;
    logic done;
    exp_t e;
    exp_q.push_back('{hit: hit, way: way, err: err});
    if (do_wb) wb_q.push_back(wbt);
    w0 = wr_cnt;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_rw = rw; bus.req_index = idx;
    bus.req_tag = tg; bus.req_domain = dom;
    if (co_cfg) begin
      cfg_we = 1'b1; cfg_domain = dom; cfg_mask = '0;
    end
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    cfg_we = 1'b0;
    lat = 1; done = 1'b0; cyc = 0;
    while (!done && cyc < 200) begin
      if (bus.resp_valid) begin
        e = exp_q.pop_front();
        chk("resp_hit", 32'(bus.resp_hit), 32'(e.hit));
        chk("resp_way", 32'(bus.resp_way), 32'(e.way));
        chk("resp_err", 32'(bus.resp_err), 32'(e.err));
        if (lat_exp != 0) chk("resp_lat", lat, lat_exp);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        done = 1'b1;
      end else begin
        if (wb_valid) begin
          if (wb_q.size() == 0) chk("wb_unexpected", 32'd1, 32'd0);
          else chk("wb_tag", 32'(wb_tag), 32'(wb_q.pop_front()));
          wb_ready = 1'b1;
          @(negedge clk);
          wb_ready = 1'b0;
        end else if (fill_valid) begin
          fill_done = 1'b1;
          @(negedge clk);
          fill_done = 1'b0;
        end else begin
          @(negedge clk);
        end
        cyc++; lat++;
      end
    end
    chk("resp_timeout", 32'(done), 32'd1);
    chk("tag_writes", wr_cnt - w0, nwr);
    chk("wb_left", wb_q.size(), 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; clr = 1'b1;
    bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_index = '0;
    bus.req_tag = '0; bus.req_domain = '0; bus.resp_ready = 1'b0;
    wb_ready = 1'b0; fill_done = 1'b0;
    cfg_we = 1'b0; cfg_domain = '0; cfg_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_fill_valid", 32'(fill_valid), 32'd0);
    chk("rst_tag_we", 32'(tag_req_we), 32'd0);
    rst = 1'b0;

    // Cold miss, then read hit, write hit (clean), write hit (dirty)
    txn(1'b0, 10'd5, 18'h1A, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 1, 1'b0, '0);
    chk("fill_way0", 32'(mem[5][0]), 32'({1'b1, 1'b0, 18'h1A}));
    txn(1'b0, 10'd5, 18'h1A, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 2, 0, 1'b0, '0);
    txn(1'b1, 10'd5, 18'h1A, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 3, 1, 1'b0, '0);
    chk("dirty_way0", 32'(mem[5][0]), 32'({1'b1, 1'b1, 18'h1A}));
    txn(1'b1, 10'd5, 18'h1A, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 2, 0, 1'b0, '0);

    // Domain 1 owns ways 2,3: free fills, then round-robin 2,3,2
    cfg(2'd1, 4'b1100);
    txn(1'b1, 10'd7, 18'h100, 2'd1, 1'b0, 1'b0, 2'd2, 1'b0, 0, 1, 1'b0, '0);
    txn(1'b1, 10'd7, 18'h101, 2'd1, 1'b0, 1'b0, 2'd3, 1'b0, 0, 1, 1'b0, '0);
    txn(1'b0, 10'd7, 18'h102, 2'd1, 1'b0, 1'b0, 2'd2, 1'b0, 0, 1, 1'b1, 18'h100);
    chk("rr_fill2", 32'(mem[7][2]), 32'({1'b1, 1'b0, 18'h102}));
    txn(1'b0, 10'd7, 18'h103, 2'd1, 1'b0, 1'b0, 2'd3, 1'b0, 0, 1, 1'b1, 18'h101);
    txn(1'b0, 10'd7, 18'h104, 2'd1, 1'b0, 1'b0, 2'd2, 1'b0, 0, 1, 1'b0, '0);
    chk("rr_fill3", 32'(mem[7][2]), 32'({1'b1, 1'b0, 18'h104}));

    // Isolation: dom1 must not hit dom0's way0
    txn(1'b0, 10'd5, 18'h1A, 2'd1, 1'b0, 1'b0, 2'd2, 1'b0, 0, 1, 1'b0, '0);
    chk("iso_way0", 32'(mem[5][0]), 32'({1'b1, 1'b1, 18'h1A}));

    // Empty mask
    txn(1'b0, 10'd5, 18'h1A, 2'd2, 1'b0, 1'b0, 2'd0, 1'b1, 2, 0, 1'b0, '0);

    // cfg coincident with accept uses the old mask; next request sees new one
    txn(1'b0, 10'd5, 18'h1A, 2'd0, 1'b1, 1'b1, 2'd0, 1'b0, 2, 0, 1'b0, '0);
    txn(1'b0, 10'd5, 18'h1A, 2'd0, 1'b0, 1'b0, 2'd0, 1'b1, 2, 0, 1'b0, '0);
    cfg(2'd0, 4'b1111);

    // Reset in the middle of a refill
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_index = 10'd9;
    bus.req_tag = 18'h55; bus.req_domain = 2'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc = 0;
    while (!fill_valid && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    chk("fill_seen", 32'(fill_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", 32'(bus.req_ready), 32'd1);
    chk("midrst_fill", 32'(fill_valid), 32'd0);
    chk("midrst_array", 32'(mem[9][0]), 32'd0);
    txn(1'b0, 10'd5, 18'h1A, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 2, 0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
